pipe_bus_arbiter: RTL and testbench

Shares the memory bus between the pipelined CPU and one external bus master (DMA / front panel).
- Raises BusRequest to Pipeline Stage 1. Stage 1 microcode then asserts FetchSuppress, and stage 1 zeroes the instruction byte it passes on.
- Grants the bus to the master only in slots where fetch is suppressed and no pipeline data cycle is active.
- Bounds burst length and enforces a hold-off between bursts so the CPU keeps making progress.

---
 rtl/pipe_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_pipe_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pipe_bus_arbiter
// Purpose  : Shares the memory bus between the pipelined CPU and one external
//            bus master (DMA / front panel).
//
//            The arbiter asks pipeline stage 1 for the bus. Stage 1 then
//            suppresses instruction fetch. The master is granted only in
//            slots where fetch is suppressed and no pipeline data cycle is
//            running. Each burst is capped at MAX_BURST cycles and is followed
//            by a hold-off so the CPU keeps making progress.
//
// Ports    : ClockIn        in   system clock, rising edge
//            Reset_n        in   asynchronous active-low reset
//            DmaReq         in   level request from the external master
//            FetchSuppress  in   stage 1 is not fetching this cycle
//            PipeMemCycle   in   pipeline stage 2/3 owns the data bus
//            BusRequest     out  request to stage 1 (registered)
//            DmaGrant       out  master may drive the bus (registered)
//            DmaBurstEnd    out  pulse on the cycle after the last grant
//            BusOwner       out  00 fetch, 01 pipeline data, 10 DMA (comb.)
//            ConflictErr    out  sticky: PipeMemCycle seen during a grant
//            GrantCount     out  granted-cycle counter (optional, see below)
//
// Options  : PIPE_BUS_ARB_STATS_EN - when defined, adds the 16-bit GrantCount
//            output, which counts cycles with DmaGrant=1 and wraps.
//
// Revision : 1.0 - initial release
// ============================================================================
module pipe_bus_arbiter #(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned HOLDOFF   = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic        ClockIn,
  input  logic        Reset_n,
  input  logic        DmaReq,
  input  logic        FetchSuppress,
  input  logic        PipeMemCycle,
  output logic        BusRequest,
  output logic        DmaGrant,
  output logic        DmaBurstEnd,
  output logic [1:0]  BusOwner,
`ifdef PIPE_BUS_ARB_STATS_EN
  output logic [15:0] GrantCount,
`endif
  output logic        ConflictErr
);

  // Both limits are truncated to the counter width. A burst limit of zero
  // would never terminate, so it is promoted to a single-cycle burst.
  localparam logic [CNT_W-1:0] BURST_TRUNC  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] BURST_LOAD   = (BURST_TRUNC == '0) ? CNT_ONE : BURST_TRUNC;
  localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] holdoff_cnt;

  // The master always wins ownership while granted; a pipeline data cycle
  // overlapping a grant is reported through ConflictErr instead.
  assign BusOwner = DmaGrant ? 2'b10 : (PipeMemCycle ? 2'b01 : 2'b00);

  always_ff @(posedge ClockIn or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      burst_cnt   <= '0;
      holdoff_cnt <= '0;
      BusRequest  <= 1'b0;
      DmaGrant    <= 1'b0;
      DmaBurstEnd <= 1'b0;
      ConflictErr <= 1'b0;
    end else begin
      DmaBurstEnd <= 1'b0;
      case (state)
        ST_IDLE: begin
          BusRequest <= 1'b0;
          DmaGrant   <= 1'b0;
          if (holdoff_cnt != '0) begin
            holdoff_cnt <= holdoff_cnt - CNT_ONE;
          end else if (DmaReq) begin
            state      <= ST_REQ;
            BusRequest <= 1'b1;
          end
        end

        ST_REQ: begin
          if (!DmaReq) begin
            // Withdrawn before a slot opened: quietly back off, no pulse.
            state      <= ST_IDLE;
            BusRequest <= 1'b0;
          end else if (FetchSuppress && !PipeMemCycle) begin
            state     <= ST_GRANT;
            DmaGrant  <= 1'b1;
            burst_cnt <= BURST_LOAD;
          end
        end

        ST_GRANT: begin
          burst_cnt <= burst_cnt - CNT_ONE;
          if (PipeMemCycle) begin
            ConflictErr <= 1'b1;
          end
          // burst_cnt == 1 marks the final granted cycle of the burst.
          if (PipeMemCycle || !DmaReq || (burst_cnt == CNT_ONE)) begin
            state       <= ST_RELEASE;
            DmaGrant    <= 1'b0;
            BusRequest  <= 1'b0;
            DmaBurstEnd <= 1'b1;
            // Loaded on entry to RELEASE and counted down from the RELEASE
            // cycle onward, so RELEASE is the first hold-off cycle and the
            // request stays low for HOLDOFF+1 cycles in total.
            holdoff_cnt <= HOLDOFF_LOAD;
          end
        end

        ST_RELEASE: begin
          state <= ST_IDLE;
          if (holdoff_cnt != '0) begin
            holdoff_cnt <= holdoff_cnt - CNT_ONE;
          end
        end

        default: begin
          state      <= ST_IDLE;
          BusRequest <= 1'b0;
          DmaGrant   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_BUS_ARB_STATS_EN
  always_ff @(posedge ClockIn or negedge Reset_n) begin
    if (!Reset_n) begin
      GrantCount <= 16'h0000;
    end else if (DmaGrant) begin
      GrantCount <= GrantCount + 16'h0001;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_bus_arbiter
// Purpose  : Directed self-checking bench for pipe_bus_arbiter with default
//            parameters (MAX_BURST=16, HOLDOFF=4). Inputs change on the
//            falling clock edge; outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_bus_arbiter;

  logic        ClockIn       = 1'b0;
  logic        Reset_n       = 1'b0;
  logic        DmaReq        = 1'b0;
  logic        FetchSuppress = 1'b0;
  logic        PipeMemCycle  = 1'b0;
  logic        BusRequest;
  logic        DmaGrant;
  logic        DmaBurstEnd;
  logic [1:0]  BusOwner;
  logic        ConflictErr;
`ifdef PIPE_BUS_ARB_STATS_EN
  logic [15:0] GrantCount;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 ClockIn = ~ClockIn;

  pipe_bus_arbiter #(
    .MAX_BURST (16),
    .HOLDOFF   (4),
    .CNT_W     (8)
  ) dut (
    .ClockIn       (ClockIn),
    .Reset_n       (Reset_n),
    .DmaReq        (DmaReq),
    .FetchSuppress (FetchSuppress),
    .PipeMemCycle  (PipeMemCycle),
    .BusRequest    (BusRequest),
    .DmaGrant      (DmaGrant),
    .DmaBurstEnd   (DmaBurstEnd),
    .BusOwner      (BusOwner),
`ifdef PIPE_BUS_ARB_STATS_EN
    .GrantCount    (GrantCount),
`endif
    .ConflictErr   (ConflictErr)
  );

  // Leaves the DUT idle and out of reset at a falling edge.
  task automatic apply_reset;
    @(negedge ClockIn);
    Reset_n       = 1'b0;
    DmaReq        = 1'b0;
    FetchSuppress = 1'b0;
    PipeMemCycle  = 1'b0;
    @(negedge ClockIn);
    @(negedge ClockIn);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    #1;
    n_cmp++; if (BusRequest !== 1'b0) begin n_fail++; $display("FAIL reset_busreq got=%b exp=0", BusRequest); end
    n_cmp++; if (DmaGrant !== 1'b0) begin n_fail++; $display("FAIL reset_grant got=%b exp=0", DmaGrant); end
    n_cmp++; if (DmaBurstEnd !== 1'b0) begin n_fail++; $display("FAIL reset_burstend got=%b exp=0", DmaBurstEnd); end
    n_cmp++; if (ConflictErr !== 1'b0) begin n_fail++; $display("FAIL reset_conflict got=%b exp=0", ConflictErr); end
    n_cmp++; if (BusOwner !== 2'b00) begin n_fail++; $display("FAIL reset_owner got=%b exp=00", BusOwner); end
`ifdef PIPE_BUS_ARB_STATS_EN
    n_cmp++; if (GrantCount !== 16'h0000) begin n_fail++; $display("FAIL reset_grantcount got=%0d exp=0", GrantCount); end
`endif
    @(negedge ClockIn);
    @(negedge ClockIn);
    Reset_n = 1'b1;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 20; i++) begin
      @(negedge ClockIn);
      n_cmp++; if (BusRequest !== 1'b0) begin n_fail++; $display("FAIL idle_busreq cyc=%0d got=%b exp=0", i, BusRequest); end
      n_cmp++; if (DmaGrant !== 1'b0) begin n_fail++; $display("FAIL idle_grant cyc=%0d got=%b exp=0", i, DmaGrant); end
      n_cmp++; if (BusOwner !== 2'b00) begin n_fail++; $display("FAIL idle_owner cyc=%0d got=%b exp=00", i, BusOwner); end
    end
  endtask

  // N0 = first falling edge with BusRequest high. FetchSuppress rises at N2,
  // so grants run N3..N18 (16 cycles), RELEASE at N19, request low N19..N23,
  // reasserted at N24 and granted again at N25.
  task automatic test_basic_burst;
    int waited;
    int grants;
    logic exp_g, exp_be, exp_br;
    DmaReq        = 1'b1;
    FetchSuppress = 1'b0;
    PipeMemCycle  = 1'b0;
    waited = 0;
    do begin
      @(negedge ClockIn);
      waited++;
    end while (BusRequest !== 1'b1 && waited < 10);
    n_cmp++; if (waited != 1) begin n_fail++; $display("FAIL basic_req_latency got=%0d exp=1", waited); end
    grants = 0;
    for (int i = 0; i <= 25; i++) begin
      if (i > 0) @(negedge ClockIn);
      exp_g  = ((i >= 3) && (i <= 18)) || (i == 25);
      exp_be = (i == 19);
      exp_br = (i <= 18) || (i >= 24);
      if (i <= 24 && DmaGrant === 1'b1) grants++;
      n_cmp++; if (DmaGrant !== exp_g) begin n_fail++; $display("FAIL basic_grant cyc=%0d got=%b exp=%b", i, DmaGrant, exp_g); end
      n_cmp++; if (DmaBurstEnd !== exp_be) begin n_fail++; $display("FAIL basic_burstend cyc=%0d got=%b exp=%b", i, DmaBurstEnd, exp_be); end
      n_cmp++; if (BusRequest !== exp_br) begin n_fail++; $display("FAIL basic_busreq cyc=%0d got=%b exp=%b", i, BusRequest, exp_br); end
      n_cmp++; if (BusOwner !== (exp_g ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL basic_owner cyc=%0d got=%b exp=%b", i, BusOwner, exp_g ? 2'b10 : 2'b00); end
      if (i == 2) FetchSuppress = 1'b1;
    end
    n_cmp++; if (grants != 16) begin n_fail++; $display("FAIL basic_grant_total got=%0d exp=16", grants); end
    apply_reset();
  endtask

  task automatic test_early_withdraw;
    int grants;
    logic exp_g, exp_be, exp_br;
    DmaReq        = 1'b1;
    FetchSuppress = 1'b1;
    grants = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge ClockIn);
      exp_g  = (i >= 2) && (i <= 4);
      exp_be = (i == 5);
      exp_br = (i <= 4);
      if (DmaGrant === 1'b1) grants++;
      n_cmp++; if (DmaGrant !== exp_g) begin n_fail++; $display("FAIL early_grant cyc=%0d got=%b exp=%b", i, DmaGrant, exp_g); end
      n_cmp++; if (DmaBurstEnd !== exp_be) begin n_fail++; $display("FAIL early_burstend cyc=%0d got=%b exp=%b", i, DmaBurstEnd, exp_be); end
      n_cmp++; if (BusRequest !== exp_br) begin n_fail++; $display("FAIL early_busreq cyc=%0d got=%b exp=%b", i, BusRequest, exp_br); end
      n_cmp++; if (ConflictErr !== 1'b0) begin n_fail++; $display("FAIL early_conflict cyc=%0d got=%b exp=0", i, ConflictErr); end
      if (i == 4) DmaReq = 1'b0;
    end
    n_cmp++; if (grants != 3) begin n_fail++; $display("FAIL early_grant_total got=%0d exp=3", grants); end
    apply_reset();
  endtask

  task automatic test_withdraw_before_slot;
    DmaReq        = 1'b1;
    FetchSuppress = 1'b0;
    @(negedge ClockIn);
    n_cmp++; if (BusRequest !== 1'b1) begin n_fail++; $display("FAIL nslot_busreq got=%b exp=1", BusRequest); end
    DmaReq = 1'b0;
    for (int i = 2; i <= 7; i++) begin
      @(negedge ClockIn);
      n_cmp++; if (BusRequest !== 1'b0) begin n_fail++; $display("FAIL nslot_busreq_low cyc=%0d got=%b exp=0", i, BusRequest); end
      n_cmp++; if (DmaGrant !== 1'b0) begin n_fail++; $display("FAIL nslot_grant cyc=%0d got=%b exp=0", i, DmaGrant); end
      n_cmp++; if (DmaBurstEnd !== 1'b0) begin n_fail++; $display("FAIL nslot_burstend cyc=%0d got=%b exp=0", i, DmaBurstEnd); end
    end
    PipeMemCycle = 1'b1;
    #1;
    n_cmp++; if (BusOwner !== 2'b01) begin n_fail++; $display("FAIL nslot_owner_pipe got=%b exp=01", BusOwner); end
    PipeMemCycle = 1'b0;
    apply_reset();
  endtask

  // Grants at M2..M6; PipeMemCycle raised during the 5th grant (M6).
  task automatic test_conflict;
    logic exp_g, exp_be, exp_ce;
    DmaReq        = 1'b1;
    FetchSuppress = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge ClockIn);
      exp_g  = (i >= 2) && (i <= 6);
      exp_be = (i == 7);
      exp_ce = (i >= 7);
      n_cmp++; if (DmaGrant !== exp_g) begin n_fail++; $display("FAIL conf_grant cyc=%0d got=%b exp=%b", i, DmaGrant, exp_g); end
      n_cmp++; if (DmaBurstEnd !== exp_be) begin n_fail++; $display("FAIL conf_burstend cyc=%0d got=%b exp=%b", i, DmaBurstEnd, exp_be); end
      n_cmp++; if (ConflictErr !== exp_ce) begin n_fail++; $display("FAIL conf_err cyc=%0d got=%b exp=%b", i, ConflictErr, exp_ce); end
      if (i == 6) begin
        PipeMemCycle = 1'b1;
        #1;
        n_cmp++; if (BusOwner !== 2'b10) begin n_fail++; $display("FAIL conf_owner got=%b exp=10", BusOwner); end
      end
      if (i == 7) begin
        PipeMemCycle = 1'b0;
        DmaReq       = 1'b0;
      end
    end
    apply_reset();
    n_cmp++; if (ConflictErr !== 1'b0) begin n_fail++; $display("FAIL conf_err_cleared got=%b exp=0", ConflictErr); end
  endtask

  task automatic test_async_reset;
    DmaReq        = 1'b1;
    FetchSuppress = 1'b1;
    @(negedge ClockIn);
    @(negedge ClockIn);
    n_cmp++; if (DmaGrant !== 1'b1) begin n_fail++; $display("FAIL areset_pre_grant got=%b exp=1", DmaGrant); end
    @(negedge ClockIn);
`ifdef PIPE_BUS_ARB_STATS_EN
    n_cmp++; if (GrantCount !== 16'd1) begin n_fail++; $display("FAIL areset_pre_count got=%0d exp=1", GrantCount); end
`endif
    #2;
    Reset_n = 1'b0;
    #1;
    n_cmp++; if (DmaGrant !== 1'b0) begin n_fail++; $display("FAIL areset_grant got=%b exp=0", DmaGrant); end
    n_cmp++; if (BusRequest !== 1'b0) begin n_fail++; $display("FAIL areset_busreq got=%b exp=0", BusRequest); end
`ifdef PIPE_BUS_ARB_STATS_EN
    n_cmp++; if (GrantCount !== 16'd0) begin n_fail++; $display("FAIL areset_count got=%0d exp=0", GrantCount); end
`endif
    DmaReq = 1'b0;
    @(negedge ClockIn);
    Reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic_burst();
    test_early_withdraw();
    test_withdraw_before_slot();
    test_conflict();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
